// File: rtl/stream_sorter_if.sv
// Stream sorter port bundle: input element stream, sorted output stream,
// frame statistics and an FSM state tap for checkers.
//
// Handshake rules (both streams): a transfer happens on a rising clock edge
// where valid && ready are both high. The sender keeps data/last stable while
// valid is high and ready is low. Ready may depend on block state but never
// on the same-cycle valid of the opposite side.
interface stream_sorter_if #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 5
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [WIDTH-1:0] out_median;
  logic [CW-1:0]    out_count;
  logic             dbg_state;

  // Sorter side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_median, out_count,
           dbg_state
  );

  // Source / sink side
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_median, out_count,
           dbg_state
  );
endinterface

// File: rtl/stream_sorter.sv
// Insertion-sorting frame buffer. Elements arrive one per cycle in LOAD and
// are placed into their sorted slot in a single cycle. When the frame is
// complete (DEPTH elements or in_last), the block switches to DRAIN and
// streams the sorted frame out with backpressure, exposing the median.
module stream_sorter #(
  parameter int WIDTH   = 6,
  parameter int DEPTH   = 5,
  parameter int DESCEND = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  stream_sorter_if.slave s
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {LOAD = 1'b0, DRAIN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_run;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_rd_idx;
  logic [WIDTH-1:0] r_buf [DEPTH];

  logic [DEPTH-1:0] w_keep;
  logic [WIDTH-1:0] w_ins [DEPTH];
  logic             w_accept;
  logic             w_rd_hs;
  logic             w_last_out;
  logic [CW-1:0]    w_med_idx;

  // r_run holds in_ready low until the first clock after reset release
  assign w_accept   = (r_state == LOAD) && r_run && s.in_valid;
  assign w_rd_hs    = (r_state == DRAIN) && s.out_ready;
  assign w_last_out = (r_rd_idx == r_cnt - 1'b1);
  assign w_med_idx  = (r_cnt - 1'b1) >> 1;

  assign s.out_count = r_cnt;
  assign s.dbg_state = r_state;

  // Parallel compare: slot i stays put when it is occupied and orders at or
  // before the new element (equal values stay ahead, keeping ties stable).
  always_comb begin
    w_keep = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_cnt) begin
        if (DESCEND != 0) w_keep[i] = (r_buf[i] >= s.in_data);
        else              w_keep[i] = (r_buf[i] <= s.in_data);
      end
    end
  end

  // Build the post-insertion buffer: kept slots hold, the first non-kept slot
  // takes the new element, later slots take their lower neighbour.
  always_comb begin
    w_ins[0] = w_keep[0] ? r_buf[0] : s.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      if (w_keep[i])        w_ins[i] = r_buf[i];
      else if (w_keep[i-1]) w_ins[i] = s.in_data;
      else                  w_ins[i] = r_buf[i-1];
    end
  end

  // State register; reset aborts any frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_next       = r_state;
    s.in_ready   = 1'b0;
    s.out_valid  = 1'b0;
    s.out_data   = '0;
    s.out_last   = 1'b0;
    s.out_median = '0;
    case (r_state)
      LOAD: begin
        s.in_ready = r_run;
        if (w_accept && (s.in_last || r_cnt == CW'(DEPTH - 1))) w_next = DRAIN;
      end
      DRAIN: begin
        s.out_valid  = 1'b1;
        s.out_data   = r_buf[r_rd_idx];
        s.out_last   = w_last_out;
        s.out_median = r_buf[w_med_idx];
        if (w_rd_hs && w_last_out) w_next = LOAD;
      end
      default: w_next = LOAD;
    endcase
  end

  // Buffer, element count and read pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rd_idx <= '0;
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= w_ins[i];
    end else if (w_rd_hs) begin
      if (w_last_out) begin
        r_cnt    <= '0;
        r_rd_idx <= '0;
      end else begin
        r_rd_idx <= r_rd_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stream_sorter.sv
// Bench for stream_sorter: an ascending and a descending instance receive the
// same stimulus; each has its own expected queue filled from a sort model.
module tb_stream_sorter;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [15:0] exp_a[$];
  logic [15:0] exp_d[$];
  logic [5:0]  fv[8];

  stream_sorter_if #(.WIDTH(6), .DEPTH(5)) ifa ();
  stream_sorter_if #(.WIDTH(6), .DEPTH(5)) ifd ();

  stream_sorter #(.WIDTH(6), .DEPTH(5), .DESCEND(0)) u_asc (
    .clk(clk), .rst_n(rst_n), .s(ifa.slave)
  );
  stream_sorter #(.WIDTH(6), .DEPTH(5), .DESCEND(1)) u_desc (
    .clk(clk), .rst_n(rst_n), .s(ifd.slave)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input logic v, input logic [5:0] d, input logic l);
    ifa.in_valid = v; ifa.in_data = d; ifa.in_last = l;
    ifd.in_valid = v; ifd.in_data = d; ifd.in_last = l;
  endtask

  // Expected entry: {last, median[5:0], count[2:0], data[5:0]}
  task automatic push_exp(input int n);
    logic [5:0] s[8];
    logic [5:0] t;
    for (int i = 0; i < n; i++) s[i] = fv[i];
    for (int i = 1; i < n; i++)
      for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
        t = s[j]; s[j] = s[j-1]; s[j-1] = t;
      end
    for (int k = 0; k < n; k++) begin
      exp_a.push_back({(k == n - 1), s[(n - 1) >> 1], 3'(n), s[k]});
      exp_d.push_back({(k == n - 1), s[n - 1 - ((n - 1) >> 1)], 3'(n), s[n - 1 - k]});
    end
  endtask

  // Present fv[0..n-1] one per cycle; every step must find the block idle
  task automatic load_frame(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("load_hs_a", {ifa.in_ready, ifa.out_valid}, 16'b10);
      chk("load_hs_d", {ifd.in_ready, ifd.out_valid}, 16'b10);
      chk("load_cnt_a", 16'(ifa.out_count), 16'(i));
      chk("load_cnt_d", 16'(ifd.out_count), 16'(i));
      drive_in(1'b1, fv[i], use_last && (i == n - 1));
    end
    push_exp(n);
  endtask

  // Drain with optional stall window, early stop and in_valid held high
  task automatic drain(input int stall_after, input int stall_len, input int stop_after,
                       input bit hold, input logic [5:0] hold_data);
    int popped  = 0;
    int stalled = 0;
    bit done    = 0;
    bit r;
    for (int guard = 0; guard < 40 && !done; guard++) begin
      @(negedge clk);
      if (hold) drive_in(1'b1, hold_data, 1'b0);
      else      drive_in(1'b0, 'x, 'x);
      r = !(popped == stall_after && stalled < stall_len);
      if (!r) stalled++;
      ifa.out_ready = r;
      ifd.out_ready = r;
      chk("drain_hs_a", {ifa.in_ready, ifa.out_valid}, 16'b01);
      chk("drain_hs_d", {ifd.in_ready, ifd.out_valid}, 16'b01);
      if (exp_a.size() == 0 || exp_d.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL exp_q_empty observed=output expected=none");
        done = 1;
      end else begin
        chk("out_a", {ifa.out_last, ifa.out_median, ifa.out_count, ifa.out_data}, exp_a[0]);
        chk("out_d", {ifd.out_last, ifd.out_median, ifd.out_count, ifd.out_data}, exp_d[0]);
        if (r) begin
          if (exp_a[0][15]) done = 1;
          void'(exp_a.pop_front());
          void'(exp_d.pop_front());
          popped++;
          if (popped == stop_after) done = 1;
        end
      end
    end
    vectors++;
    assert (done) else begin
      miscompares++;
      $error("FAIL drain_timeout observed=%0d expected=frame_end", popped);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    drive_in(1'b0, '0, 1'b0);
    ifa.out_ready = 1'b1;
    ifd.out_ready = 1'b1;
    #1;
    chk("reset_a", {ifa.in_ready, ifa.out_valid, ifa.out_last, ifa.out_data,
                    ifa.out_median, 1'b0}, 16'h0);
    chk("reset_d", {ifd.in_ready, ifd.out_valid, ifd.out_last, ifd.out_data,
                    ifd.out_median, 1'b0}, 16'h0);
    chk("reset_cnt", {13'd0, ifa.out_count}, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full frame, no backpressure
    fv = '{6'd12, 6'd5, 6'd63, 6'd0, 6'd5, 6'd0, 6'd0, 6'd0};
    load_frame(5, 1'b0);
    drain(-1, 0, -1, 1'b0, '0);

    // Same frame with a 3-cycle stall after the 2nd output
    load_frame(5, 1'b0);
    drain(2, 3, -1, 1'b0, '0);

    // Short frames ended by in_last
    fv = '{6'd40, 6'd7, 6'd20, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    load_frame(3, 1'b1);
    drain(-1, 0, -1, 1'b0, '0);
    fv = '{6'd9, 6'd3, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    load_frame(2, 1'b1);
    drain(-1, 0, -1, 1'b0, '0);

    // Monotonic input (descending instance reverses it)
    fv = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd0, 6'd0, 6'd0};
    load_frame(5, 1'b0);
    drain(-1, 0, -1, 1'b0, '0);

    // Reset in mid-DRAIN after 2 outputs
    fv = '{6'd12, 6'd5, 6'd63, 6'd0, 6'd5, 6'd0, 6'd0, 6'd0};
    load_frame(5, 1'b0);
    drain(-1, 0, 2, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_a", {ifa.in_ready, ifa.out_valid, ifa.out_data, ifa.out_count}, 16'h0);
    chk("midrst_d", {ifd.in_ready, ifd.out_valid, ifd.out_data, ifd.out_count}, 16'h0);
    exp_a.delete();
    exp_d.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fv = '{6'd63, 6'd63, 6'd0, 6'd1, 6'd2, 6'd0, 6'd0, 6'd0};
    load_frame(5, 1'b0);
    drain(-1, 0, -1, 1'b0, '0);

    // Back-to-back frames with in_valid held high through DRAIN
    fv = '{6'd10, 6'd30, 6'd20, 6'd50, 6'd40, 6'd0, 6'd0, 6'd0};
    load_frame(5, 1'b0);
    drain(-1, 0, -1, 1'b1, 6'd7);
    fv = '{6'd7, 6'd1, 6'd9, 6'd1, 6'd0, 6'd0, 6'd0, 6'd0};
    load_frame(4, 1'b1);
    drain(-1, 0, -1, 1'b0, '0);

    @(negedge clk);
    chk("idle_a", {ifa.in_ready, ifa.out_valid, 11'd0, ifa.out_count}, 16'h8000);
    chk("idle_d", {ifd.in_ready, ifd.out_valid, 11'd0, ifd.out_count}, 16'h8000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stream_sorter.md
Name: stream_sorter

Overview:
- Parametrised sequential successor to the team's fixed 5-input combinational sorting network.
- Accepts a frame of up to DEPTH unsigned values, one per cycle, over a valid/ready handshake, and keeps them sorted on arrival by insertion.
- Once the frame is complete, it streams the values out in sorted order with backpressure and exposes the frame median.
- Sits between a sample source and downstream rank/median consumers.

Parameters:
WIDTH, 6, bit width of each unsigned element
DEPTH, 5, maximum elements per frame (>=2)
DESCEND, 0, 0 = ascending output order, 1 = descending

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input element valid
in_data  in  WIDTH  input element
in_last  in  1  marks final element of a short frame; qualified by in_valid
in_ready  out  1  block can accept an element
out_ready  in  1  downstream accepts out_data
out_valid  out  1  out_data valid
out_data  out  WIDTH  current sorted element
out_last  out  1  out_data is last element of frame
out_median  out  WIDTH  frame median, valid while out_valid
out_count  out  $clog2(DEPTH+1)  number of elements in current frame

Behaviour:
- Reset (async assert, sync release) puts the block in LOAD with cnt=0 and rd_idx=0, and clears the buffer to 0.
- Output values during reset: in_ready=0, out_valid=0, out_last=0, out_data=0, out_median=0, out_count=0.
- On the first clk after release, in_ready=1.
- State LOAD:
  - in_ready=1, out_valid=0.
  - An accept is in_valid && in_ready.
  - On accept, the element is inserted at position p = number of stored elements e with e<=in_data (ascending) or e>=in_data (DESCEND=1).
  - Entries at index >=p shift up one; cnt increments. Insertion is single-cycle, with parallel compares across all DEPTH slots.
  - Ties are stable: a new element goes after existing equal values.
  - If the accept brings cnt to DEPTH, or in_last=1, the next state is DRAIN.
  - in_last without in_valid is ignored.
- State DRAIN:
  - in_ready=0; in_valid is ignored and nothing is consumed.
  - out_valid=1, out_data=buf[rd_idx], out_last=(rd_idx==cnt-1).
  - out_median=buf[(cnt-1)>>1]. For even cnt this is the lower-index middle element. It is held constant through DRAIN.
  - out_count=cnt, held throughout DRAIN.
  - On out_valid && out_ready, rd_idx increments.
  - On the handshake with out_last=1: the next state is LOAD, cnt=0, rd_idx=0, and in_ready=1 on the following cycle.
  - When out_ready=0, out_data, out_last and rd_idx hold.
- Outside DRAIN: out_data=0, out_median=0, out_last=0. out_count shows the running cnt during LOAD.
- Latency:
  - The final accept at cycle t gives out_valid=1 at t+1.
  - With out_ready tied high, a full frame takes DEPTH accept cycles plus DEPTH output cycles.
  - No overlap between load and drain.
- Width rules:
  - Comparisons are unsigned WIDTH-bit.
  - cnt and rd_idx are $clog2(DEPTH+1) bits and never exceed DEPTH. rd_idx never exceeds cnt-1 while reading.
  - No wrap-around is possible because LOAD exits at cnt==DEPTH.
- Reset mid-operation, in either state, aborts the frame:
  - Partial buffer contents are discarded.
  - No spurious out_valid appears after release.
- in_data/in_last are sampled only on accept and may be X otherwise.

Test Plan:
1. DEPTH=5, WIDTH=6, ascending; feed 12,5,63,0,5 back-to-back, out_ready=1 -> out_valid rises the cycle after the 5th accept. Outputs are 0,5,5,12,63 on consecutive cycles with out_last on 63. out_median=5, out_count=5, in_ready=0 for those 5 cycles, then 1.
2. Backpressure: same frame, out_ready low for 3 cycles after the 2nd output -> out_data holds 5 with out_valid=1 for those cycles. Remaining outputs 5,12,63 follow, and no element is lost or duplicated.
3. Short frame: feed 40,7,20 with in_last on 20 -> outputs 7,20,40, out_count=3, out_median=20, out_last on 40. A 2-element frame 9,3 gives outputs 3,9 with out_median=3.
4. DESCEND=1 instance: feed 1,2,3,4,5 -> outputs 5,4,3,2,1 with out_median=3.
5. Reset: assert rst_n=0 in mid-DRAIN after 2 outputs -> out_valid, out_data and out_count go 0 immediately, without waiting for clk. After release, frame 63,63,0,1,2 outputs 0,1,2,63,63 with out_median=2.
6. Back-to-back frames with in_valid held high throughout DRAIN -> no accepts during DRAIN. The next frame's first accept happens in the cycle after the out_last handshake, and both frames output correctly sorted.
